// File: rtl/main_mem_responder.sv
// Main-memory responder: fixed-latency word read port, write port, host port.
// Optional `RESP_COUNTERS_EN` adds the mem-port read/write access counters.
module main_mem_responder #(
    parameter int DATA_WIDTH          = 32,
    parameter int MAIN_MEM_ADDR_WIDTH = 32,
    parameter int STORE_ADDR_WIDTH    = 12,
    parameter int RD_LATENCY          = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           mem_rd_en,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [DATA_WIDTH-1:0]          mem_rd_data,
    output logic                           mem_rd_valid,
    input  logic                           mem_wr_en,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]          mem_wr_data,
    input  logic                           host_req,
    input  logic                           host_we,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0]          host_wr_data,
    output logic                           host_ack,
    output logic [DATA_WIDTH-1:0]          host_rd_data,
    output logic                           oob_err,
    output logic [31:0]                    rd_count,
    output logic [31:0]                    wr_count
);

    localparam int DEPTH = 1 << STORE_ADDR_WIDTH;

    typedef enum logic {
        IDLE,
        HRD
    } state_t;

    logic [DATA_WIDTH-1:0]       store [DEPTH];
    logic [STORE_ADDR_WIDTH-1:0] rd_idx;
    logic [STORE_ADDR_WIDTH-1:0] wr_idx;
    logic [STORE_ADDR_WIDTH-1:0] host_idx;
    logic                        rd_inr;
    logic                        wr_inr;
    logic                        host_inr;
    logic [DATA_WIDTH-1:0]       rd_word;
    logic [DATA_WIDTH-1:0]       host_word;
    logic [DATA_WIDTH-1:0]       host_word_q;
    logic                        arr_we;
    logic [STORE_ADDR_WIDTH-1:0] arr_idx;
    logic [DATA_WIDTH-1:0]       arr_data;
    logic                        host_go;
    logic                        oob_hit;
    state_t                      state_q;
    state_t                      state_d;
    logic [RD_LATENCY-1:0]       v_q;
    logic [DATA_WIDTH-1:0]       d_q [RD_LATENCY];

    assign rd_idx   = mem_rd_addr[STORE_ADDR_WIDTH-1:0];
    assign wr_idx   = mem_wr_addr[STORE_ADDR_WIDTH-1:0];
    assign host_idx = host_addr[STORE_ADDR_WIDTH-1:0];
    assign rd_inr   = (mem_rd_addr >> STORE_ADDR_WIDTH) == '0;
    assign wr_inr   = (mem_wr_addr >> STORE_ADDR_WIDTH) == '0;
    assign host_inr = (host_addr >> STORE_ADDR_WIDTH) == '0;

    // Write-first: a same-cycle in-range write to the read address forwards.
    always_comb begin
        rd_word = '0;
        if (rd_inr) begin
            rd_word = store[rd_idx];
            if (mem_wr_en && wr_inr && (mem_wr_addr == mem_rd_addr)) begin
                rd_word = mem_wr_data;
            end
        end
    end

    assign host_word = host_inr ? store[host_idx] : '0;

    // Host only gets a slot with both mem ports quiet; the ack cycle itself is
    // skipped so a requester still holding host_req is not serviced twice.
    always_comb begin
        state_d = state_q;
        host_go = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host_req && !mem_rd_en && !mem_wr_en && !host_ack) begin
                    host_go = 1'b1;
                    if (!host_we) begin
                        state_d = HRD;
                    end
                end
            end
            HRD:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arr_we   = 1'b0;
        arr_idx  = wr_idx;
        arr_data = mem_wr_data;
        if (mem_wr_en) begin
            arr_we = wr_inr;
        end else if (host_go && host_we) begin
            arr_we   = host_inr;
            arr_idx  = host_idx;
            arr_data = host_wr_data;
        end
    end

    assign oob_hit = (mem_rd_en && !rd_inr) || (mem_wr_en && !wr_inr) ||
                     (host_go && !host_inr);

    always_ff @(posedge clk) begin
        if (arr_we) begin
            store[arr_idx] <= arr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            host_ack     <= 1'b0;
            host_word_q  <= '0;
            host_rd_data <= '0;
            oob_err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            host_ack <= host_go;
            if (host_go && !host_we) begin
                host_word_q <= host_word;
            end
            if (state_q == HRD) begin
                host_rd_data <= host_word_q;
            end
            if (oob_hit) begin
                oob_err <= 1'b1;
            end
        end
    end

    // Data only moves with its valid, so the last stage holds between strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= mem_rd_en;
            if (mem_rd_en) begin
                d_q[0] <= rd_word;
            end
            for (int i = 1; i < RD_LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                if (v_q[i-1]) begin
                    d_q[i] <= d_q[i-1];
                end
            end
        end
    end

    assign mem_rd_valid = v_q[RD_LATENCY-1];
    assign mem_rd_data  = d_q[RD_LATENCY-1];

`ifdef RESP_COUNTERS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (mem_rd_en) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
            if (mem_wr_en) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder; instance a uses RD_LATENCY=3,
// instance b RD_LATENCY=4, both driven by the same stimulus.
module tb_main_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        host_req;
    logic        host_we;
    logic [31:0] host_addr;
    logic [31:0] host_wr_data;

    logic [31:0] rd_data_a, rd_data_b;
    logic        rd_valid_a, rd_valid_b;
    logic        ack_a, ack_b;
    logic [31:0] hrd_a, hrd_b;
    logic        oob_a, oob_b;
    logic [31:0] rdc_a, rdc_b;
    logic [31:0] wrc_a, wrc_b;

    int checks = 0;
    int errors = 0;

`ifdef RESP_COUNTERS_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    always #5 clk = ~clk;

    main_mem_responder #(.RD_LATENCY(3)) dut_a (
        .clk(clk), .reset(reset),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(rd_data_a), .mem_rd_valid(rd_valid_a),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wr_data(host_wr_data), .host_ack(ack_a),
        .host_rd_data(hrd_a), .oob_err(oob_a),
        .rd_count(rdc_a), .wr_count(wrc_a)
    );

    main_mem_responder #(.RD_LATENCY(4)) dut_b (
        .clk(clk), .reset(reset),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(rd_data_b), .mem_rd_valid(rd_valid_b),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wr_data(host_wr_data), .host_ack(ack_b),
        .host_rd_data(hrd_b), .oob_err(oob_b),
        .rd_count(rdc_b), .wr_count(wrc_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_rd_en = 1'b0; mem_rd_addr = '0;
        mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wr_data = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wr_data = d;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (ack_a) got = 1;
        end
        host_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL host_wr_ack addr=%0h got=0 want=1", a);
        end
    endtask

    task automatic host_read(input logic [31:0] a, output logic [31:0] d);
        bit got = 0;
        host_req = 1'b1; host_we = 1'b0; host_addr = a;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (ack_a) got = 1;
        end
        host_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL host_rd_ack addr=%0h got=0 want=1", a);
        end
        tick();
        d = hrd_a;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({rd_valid_a, ack_a, oob_a} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags_a got=%b want=000", {rd_valid_a, ack_a, oob_a});
        end
        checks++;
        if ({rd_data_a, hrd_a, rdc_a, wrc_a} !== 128'd0) begin
            errors++;
            $display("FAIL reset_words_a got=%h want=0", {rd_data_a, hrd_a, rdc_a, wrc_a});
        end
        checks++;
        if ({rd_valid_b, ack_b, oob_b, rd_data_b, hrd_b, rdc_b, wrc_b} !== '0) begin
            errors++;
            $display("FAIL reset_b got=%h want=0",
                     {rd_valid_b, ack_b, oob_b, rd_data_b, hrd_b, rdc_b, wrc_b});
        end
    endtask

    task automatic test_host();
        logic [31:0] d;
        do_reset();
        host_write(32'd5, 32'hDEADBEEF);
        host_read(32'd5, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL host_rd_data got=%h want=deadbeef", d);
        end
        checks++;
        if (ack_a !== 1'b0) begin
            errors++;
            $display("FAIL host_ack_strobe got=%b want=0", ack_a);
        end
    endtask

    task automatic test_back_to_back();
        int nv3 = 0;
        int nv4 = 0;
        do_reset();
        for (int i = 0; i < 4; i++) host_write(i, 32'd10 + i);
        for (int t = 1; t <= 9; t++) begin
            mem_rd_en   = (t <= 4);
            mem_rd_addr = (t <= 4) ? t - 1 : 0;
            tick();
            if (rd_valid_a) nv3++;
            if (rd_valid_b) nv4++;
            checks++;
            if (rd_valid_a !== (t >= 3 && t <= 6)) begin
                errors++;
                $display("FAIL b2b_valid3 t=%0d got=%b", t, rd_valid_a);
            end
            if (t >= 3 && t <= 6) begin
                checks++;
                if (rd_data_a !== 32'd10 + t - 3) begin
                    errors++;
                    $display("FAIL b2b_data3 t=%0d got=%0d want=%0d", t, rd_data_a, 10 + t - 3);
                end
            end
            checks++;
            if (rd_valid_b !== (t >= 4 && t <= 7)) begin
                errors++;
                $display("FAIL b2b_valid4 t=%0d got=%b", t, rd_valid_b);
            end
            if (t >= 4 && t <= 7) begin
                checks++;
                if (rd_data_b !== 32'd10 + t - 4) begin
                    errors++;
                    $display("FAIL b2b_data4 t=%0d got=%0d want=%0d", t, rd_data_b, 10 + t - 4);
                end
            end
        end
        checks++;
        if (nv3 != 4 || nv4 != 4) begin
            errors++;
            $display("FAIL b2b_count got=%0d/%0d want=4/4", nv3, nv4);
        end
        checks++;
        if (rdc_a !== (CNT ? 32'd4 : 32'd0)) begin
            errors++;
            $display("FAIL b2b_rd_count got=%0d want=%0d", rdc_a, CNT ? 4 : 0);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        host_write(32'd7, 32'h11);
        mem_rd_en = 1'b1; mem_rd_addr = 32'd7;
        mem_wr_en = 1'b1; mem_wr_addr = 32'd7; mem_wr_data = 32'h55;
        tick();
        mem_rd_en = 1'b0; mem_wr_en = 1'b0;
        tick();
        tick();
        checks++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h55) begin
            errors++;
            $display("FAIL fwd_data got=%b/%h want=1/55", rd_valid_a, rd_data_a);
        end
        checks++;
        if (wrc_a !== (CNT ? 32'd1 : 32'd0) || rdc_a !== (CNT ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL fwd_counts got=%0d/%0d want=%0d", wrc_a, rdc_a, CNT ? 1 : 0);
        end
        mem_wr_en = 1'b1; mem_wr_data = 32'h66;
        tick();
        mem_wr_en = 1'b0; mem_rd_en = 1'b1;
        tick();
        mem_rd_en = 1'b0;
        tick();
        tick();
        checks++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h66) begin
            errors++;
            $display("FAIL raw_next_cycle got=%b/%h want=1/66", rd_valid_a, rd_data_a);
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        host_write(32'd0, 32'hA5A5A5A5);
        checks++;
        if (oob_a !== 1'b0) begin
            errors++;
            $display("FAIL oob_before got=%b want=0", oob_a);
        end
        mem_rd_en = 1'b1; mem_rd_addr = 32'd0;
        tick();
        mem_rd_en = 1'b0;
        tick();
        tick();
        checks++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL oob_pre_read got=%b/%h want=1/a5a5a5a5", rd_valid_a, rd_data_a);
        end
        mem_rd_en = 1'b1; mem_rd_addr = 32'h1000;
        tick();
        mem_rd_en = 1'b0;
        checks++;
        if (oob_a !== 1'b1) begin
            errors++;
            $display("FAIL oob_set got=%b want=1", oob_a);
        end
        tick();
        tick();
        checks++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 32'h0) begin
            errors++;
            $display("FAIL oob_read got=%b/%h want=1/0", rd_valid_a, rd_data_a);
        end
        mem_wr_en = 1'b1; mem_wr_addr = 32'h1000; mem_wr_data = 32'hBAD;
        tick();
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b1; mem_rd_addr = 32'd0;
        tick();
        mem_rd_en = 1'b0;
        tick();
        tick();
        checks++;
        if (rd_valid_a !== 1'b1 || rd_data_a !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL oob_write_dropped got=%b/%h want=1/a5a5a5a5", rd_valid_a, rd_data_a);
        end
        checks++;
        if (rdc_a !== (CNT ? 32'd3 : 32'd0) || wrc_a !== (CNT ? 32'd1 : 32'd0)) begin
            errors++;
            $display("FAIL oob_counts got=%0d/%0d", rdc_a, wrc_a);
        end
    endtask

    task automatic test_starvation();
        int acks = 0;
        logic [31:0] d;
        do_reset();
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'd30; host_wr_data = 32'h77;
        for (int i = 0; i < 6; i++) begin
            mem_wr_en = 1'b1; mem_wr_addr = 32'd40 + i; mem_wr_data = i;
            tick();
            if (ack_a) acks++;
        end
        mem_wr_en = 1'b0;
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL starve_no_ack got=%0d want=0", acks);
        end
        tick();
        checks++;
        if (ack_a !== 1'b1) begin
            errors++;
            $display("FAIL starve_release got=%b want=1", ack_a);
        end
        host_req = 1'b0;
        host_read(32'd30, d);
        checks++;
        if (d !== 32'h77) begin
            errors++;
            $display("FAIL starve_data got=%h want=77", d);
        end
        checks++;
        if (wrc_a !== (CNT ? 32'd6 : 32'd0)) begin
            errors++;
            $display("FAIL starve_wr_count got=%0d want=%0d", wrc_a, CNT ? 6 : 0);
        end
    endtask

    task automatic test_reset_mid_read();
        int nv = 0;
        do_reset();
        mem_rd_en = 1'b1; mem_rd_addr = 32'h1000;
        tick();
        mem_rd_en = 1'b0;
        checks++;
        if (oob_b !== 1'b1) begin
            errors++;
            $display("FAIL mid_oob_pre got=%b want=1", oob_b);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (rd_valid_a || rd_valid_b) nv++;
        checks++;
        if ({oob_b, rdc_b, wrc_b} !== 65'd0) begin
            errors++;
            $display("FAIL mid_state got=%h want=0", {oob_b, rdc_b, wrc_b});
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rd_valid_a || rd_valid_b) nv++;
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL mid_no_valid got=%0d want=0", nv);
        end
    endtask

    initial begin
        test_reset();
        test_host();
        test_back_to_back();
        test_forwarding();
        test_out_of_range();
        test_starvation();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
